// File: rtl/opcode_fetch_queue.sv
// ---------------------------------------------------------------------------
// opcode_fetch_queue
//   Front end between code memory and the opcode decoder of an 8051-class
//   core. Code bytes are assembled into complete 1/2/3-byte instructions
//   using the 8051 opcode length table. Each instruction is tagged with the
//   PC of its opcode byte and buffered in a first-word-fall-through queue.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   When defined, opcode 0xA5 is queued as a 1-byte entry flagged on
//   instr_illegal, and the assembler halts (byte_ready low) until flush or
//   reset.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   byte_valid/data/ready code byte stream handshake
//   flush, flush_pc       discard all state and restart fetch at flush_pc
//   instr_valid/ready     queue head handshake (pop on valid && ready)
//   instr_opcode/byte1/byte2/length/pc  head entry (all zero when empty)
//   instr_illegal         head entry is the trap opcode (macro only)
//   queue_count           number of buffered instructions
// ---------------------------------------------------------------------------
module opcode_fetch_queue #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             byte_valid,
    input  logic [7:0]                       byte_data,
    output logic                             byte_ready,
    input  logic                             flush,
    input  logic [ADDR_WIDTH-1:0]            flush_pc,
    output logic                             instr_valid,
    input  logic                             instr_ready,
    output logic [7:0]                       instr_opcode,
    output logic [7:0]                       instr_byte1,
    output logic [7:0]                       instr_byte2,
    output logic [1:0]                       instr_length,
    output logic [ADDR_WIDTH-1:0]            instr_pc,
`ifdef ILLEGAL_TRAP_EN
    output logic                             instr_illegal,
`endif
    output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {S_OPC = 2'd0, S_B1 = 2'd1, S_B2 = 2'd2, S_HALT = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_OPC = 2'd0, S_B1 = 2'd1, S_B2 = 2'd2} state_e;
`endif

    // 8051 instruction length from the opcode byte.
    function automatic logic [1:0] opc_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if (op[3:0] == 4'h1) begin
            len = 2'd2;                               // AJMP / ACALL
        end else if (op[3:0] >= 4'h6) begin
            case (op[7:4])                            // @Ri / Rn columns
                4'h7, 4'h8, 4'hA: len = 2'd2;
                4'hB:             len = 2'd3;         // CJNE @Ri/Rn,#,rel
                4'hD:             len = op[3] ? 2'd2 : 2'd1; // DJNZ Rn vs XCHD
                default:          len = 2'd1;
            endcase
        end else begin
            case (op)
                8'h10, 8'h20, 8'h30, 8'h90, 8'h02, 8'h12, 8'h43, 8'h53,
                8'h63, 8'hB4, 8'h75, 8'h85, 8'hB5, 8'hD5:
                    len = 2'd3;
                8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'hA0, 8'hB0, 8'hC0,
                8'hD0, 8'h42, 8'h52, 8'h62, 8'h72, 8'h82, 8'h92, 8'hA2,
                8'hB2, 8'hC2, 8'hD2, 8'h24, 8'h34, 8'h44, 8'h54, 8'h64,
                8'h74, 8'h94, 8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55,
                8'h65, 8'h95, 8'hC5, 8'hE5, 8'hF5:
                    len = 2'd2;
                default:
                    len = 2'd1;
            endcase
        end
        return len;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, start_pc_q, start_pc_d;
    logic [7:0]            opc_q, opc_d, b1_q, b1_d;
    logic [1:0]            len_q, len_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;

    logic [7:0]            opc_mem_q [QUEUE_DEPTH];
    logic [7:0]            b1_mem_q  [QUEUE_DEPTH];
    logic [7:0]            b2_mem_q  [QUEUE_DEPTH];
    logic [1:0]            len_mem_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q  [QUEUE_DEPTH];
    logic                  ill_mem_q [QUEUE_DEPTH];

    logic                  accept_s, pop_s, push_s, push_ill_s;
    logic [7:0]            push_opc_s, push_b1_s, push_b2_s;
    logic [1:0]            push_len_s, len_now_s;
    logic [ADDR_WIDTH-1:0] push_pc_s;

    assign len_now_s   = opc_len(byte_data);
    assign instr_valid = (count_q != {CW{1'b0}});
    assign accept_s    = byte_valid && byte_ready;
    // A pop coinciding with flush is swallowed by the flush itself.
    assign pop_s       = instr_valid && instr_ready && !flush;

`ifdef ILLEGAL_TRAP_EN
    assign byte_ready = reset && !flush && (count_q != CW'(QUEUE_DEPTH)) && (state_q != S_HALT);
`else
    assign byte_ready = reset && !flush && (count_q != CW'(QUEUE_DEPTH));
`endif

    // Head entry fields; forced to zero while the queue is empty.
    assign instr_opcode  = instr_valid ? opc_mem_q[rd_ptr_q] : 8'h00;
    assign instr_byte1   = instr_valid ? b1_mem_q[rd_ptr_q]  : 8'h00;
    assign instr_byte2   = instr_valid ? b2_mem_q[rd_ptr_q]  : 8'h00;
    assign instr_length  = instr_valid ? len_mem_q[rd_ptr_q] : 2'd0;
    assign instr_pc      = instr_valid ? pc_mem_q[rd_ptr_q]  : {ADDR_WIDTH{1'b0}};
`ifdef ILLEGAL_TRAP_EN
    assign instr_illegal = instr_valid ? ill_mem_q[rd_ptr_q] : 1'b0;
`endif
    assign queue_count   = count_q;

    // Assembler next state and the entry to push when an instruction completes.
    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        b1_d       = b1_q;
        len_d      = len_q;
        start_pc_d = start_pc_q;
        push_s     = 1'b0;
        push_ill_s = 1'b0;
        push_opc_s = opc_q;
        push_b1_s  = 8'h00;
        push_b2_s  = 8'h00;
        push_len_s = len_q;
        push_pc_s  = start_pc_q;
        if (accept_s) begin
            case (state_q)
                S_OPC: begin
                    opc_d      = byte_data;
                    b1_d       = 8'h00;
                    len_d      = len_now_s;
                    start_pc_d = pc_q;
                    if (len_now_s == 2'd1) begin
                        push_s     = 1'b1;
                        push_opc_s = byte_data;
                        push_len_s = 2'd1;
                        push_pc_s  = pc_q;
`ifdef ILLEGAL_TRAP_EN
                        if (byte_data == 8'hA5) begin
                            push_ill_s = 1'b1;
                            state_d    = S_HALT;
                        end else begin
                            state_d    = S_OPC;
                        end
`endif
                    end else begin
                        state_d = S_B1;
                    end
                end
                S_B1: begin
                    b1_d = byte_data;
                    if (len_q == 2'd2) begin
                        push_s    = 1'b1;
                        push_b1_s = byte_data;
                        state_d   = S_OPC;
                    end else begin
                        state_d   = S_B2;
                    end
                end
                S_B2: begin
                    push_s    = 1'b1;
                    push_b1_s = b1_q;
                    push_b2_s = byte_data;
                    state_d   = S_OPC;
                end
                default: state_d = S_OPC;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Assembler state, PC and queue pointer/count registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_OPC;
            pc_q       <= RESET_PC;
            start_pc_q <= {ADDR_WIDTH{1'b0}};
            opc_q      <= 8'h00;
            b1_q       <= 8'h00;
            len_q      <= 2'd0;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else if (flush) begin
            state_q    <= S_OPC;
            pc_q       <= flush_pc;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            b1_q       <= b1_d;
            len_q      <= len_d;
            start_pc_q <= start_pc_d;
            if (accept_s) begin
                pc_q <= pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; push only happens on an accepted byte, never under flush/reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            opc_mem_q[wr_ptr_q] <= push_opc_s;
            b1_mem_q[wr_ptr_q]  <= push_b1_s;
            b2_mem_q[wr_ptr_q]  <= push_b2_s;
            len_mem_q[wr_ptr_q] <= push_len_s;
            pc_mem_q[wr_ptr_q]  <= push_pc_s;
            ill_mem_q[wr_ptr_q] <= push_ill_s;
        end
    end

endmodule

// File: tb/tb_opcode_fetch_queue.sv
module tb_opcode_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        flush;
    logic [15:0] flush_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode, instr_byte1, instr_byte2;
    logic [1:0]  instr_length;
    logic [15:0] instr_pc;
    logic [2:0]  queue_count;
`ifdef ILLEGAL_TRAP_EN
    logic        instr_illegal;
`endif

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    opcode_fetch_queue #(.ADDR_WIDTH(16), .QUEUE_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_byte1  (instr_byte1),
        .instr_byte2  (instr_byte2),
        .instr_length (instr_length),
        .instr_pc     (instr_pc),
`ifdef ILLEGAL_TRAP_EN
        .instr_illegal(instr_illegal),
`endif
        .queue_count  (queue_count)
    );

    always #5 clock = ~clock;

    // Reference length table: one row per high nibble, one hex digit per low nibble (0..F left to right).
    function automatic int ref_len(input logic [7:0] op);
        logic [63:0] row;
        case (op[7:4])
            4'h0: row = 64'h1231_1211_1111_1111;
            4'h1: row = 64'h3231_1211_1111_1111;
            4'h2, 4'h3: row = 64'h3211_2211_1111_1111;
            4'h4, 4'h5, 4'h6: row = 64'h2223_2211_1111_1111;
            4'h7: row = 64'h2221_2322_2222_2222;
            4'h8: row = 64'h2221_1322_2222_2222;
            4'h9: row = 64'h3221_2211_1111_1111;
            4'hA: row = 64'h2221_1122_2222_2222;
            4'hB: row = 64'h2221_3333_3333_3333;
            4'hC: row = 64'h2221_1211_1111_1111;
            4'hD: row = 64'h2221_1311_2222_2222;
            default: row = 64'h1211_1211_1111_1111;
        endcase
        return int'(row[63 - 4*op[3:0] -: 4]);
    endfunction

    typedef struct packed {
        logic [7:0]  opc;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        ill;
    } ent_t;

    ent_t       m_q[$];
    logic [7:0] m_part[$];
    logic [15:0] m_pc, m_start;
    logic       m_halt;
    ent_t       m_e;
    int         m_rl;
    logic       m_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte list per instruction, queue of finished entries.
    always @(posedge clock) begin
        if (!reset) begin
            m_q.delete(); m_part.delete(); m_pc = 16'h0000; m_halt = 1'b0;
        end else if (flush) begin
            m_q.delete(); m_part.delete(); m_pc = flush_pc; m_halt = 1'b0;
        end else begin
            m_rdy = (m_q.size() != DEPTH) && !m_halt;
            if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
            if (byte_valid && m_rdy) begin
                if (m_part.size() == 0) m_start = m_pc;
                m_part.push_back(byte_data);
                m_pc = m_pc + 16'd1;
                m_rl = ref_len(m_part[0]);
                if (m_part.size() == m_rl) begin
                    m_e.opc = m_part[0];
                    m_e.b1  = (m_rl > 1) ? m_part[1] : 8'h00;
                    m_e.b2  = (m_rl > 2) ? m_part[2] : 8'h00;
                    m_e.len = 2'(m_rl);
                    m_e.pc  = m_start;
                    m_e.ill = 1'b0;
`ifdef ILLEGAL_TRAP_EN
                    if (m_part[0] == 8'hA5) begin
                        m_e.ill = 1'b1;
                        m_halt  = 1'b1;
                    end
`endif
                    m_q.push_back(m_e);
                    m_part.delete();
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            ent_t h;
            h = '0;
            if (m_q.size() != 0) h = m_q[0];
            check("valid", {31'd0, instr_valid}, {31'd0, m_q.size() != 0});
            check("opcode", {24'd0, instr_opcode}, {24'd0, h.opc});
            check("byte1", {24'd0, instr_byte1}, {24'd0, h.b1});
            check("byte2", {24'd0, instr_byte2}, {24'd0, h.b2});
            check("length", {30'd0, instr_length}, {30'd0, h.len});
            check("pc", {16'd0, instr_pc}, {16'd0, h.pc});
            check("count", {29'd0, queue_count}, 32'(m_q.size()));
            check("byte_ready", {31'd0, byte_ready},
                  {31'd0, reset && !flush && (m_q.size() != DEPTH) && !m_halt});
`ifdef ILLEGAL_TRAP_EN
            check("illegal", {31'd0, instr_illegal}, {31'd0, h.ill});
`endif
        end
    end

    task automatic cyc(input logic bv, input logic [7:0] bd, input logic ir,
                       input logic fl = 1'b0, input logic [15:0] fpc = 16'h0000);
        byte_valid  = bv;
        byte_data   = bd;
        instr_ready = ir;
        flush       = fl;
        flush_pc    = fpc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 8'h24, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        check("lit_rst_count", {29'd0, queue_count}, 32'd0);
        check("lit_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("lit_rst_ready", {31'd0, byte_ready}, 32'd0);
        check("lit_rst_opcode", {24'd0, instr_opcode}, 32'd0);

        // ADD A,#10h latency and fields
        reset = 1'b1;
        cyc(1'b1, 8'h24, 1'b0);
        check("lit_add_valid0", {31'd0, instr_valid}, 32'd0);
        cyc(1'b1, 8'h10, 1'b0);
        check("lit_add_valid", {31'd0, instr_valid}, 32'd1);
        check("lit_add_opc", {24'd0, instr_opcode}, 32'h24);
        check("lit_add_b1", {24'd0, instr_byte1}, 32'h10);
        check("lit_add_b2", {24'd0, instr_byte2}, 32'h00);
        check("lit_add_len", {30'd0, instr_length}, 32'd2);
        check("lit_add_pc", {16'd0, instr_pc}, 32'h0000);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        check("lit_pop_empty", {29'd0, queue_count}, 32'd0);

        // Mixed stream with lengths 1,3,3,1
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 16'h0000);
        cyc(1'b1, 8'h28, 1'b1);
        check("lit_mix_pc0", {16'd0, instr_pc}, 32'h0000);
        check("lit_mix_len0", {30'd0, instr_length}, 32'd1);
        cyc(1'b1, 8'h75, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h30, 1'b1);
        cyc(1'b1, 8'h55, 1'b1);
        check("lit_mix_opc1", {24'd0, instr_opcode}, 32'h75);
        check("lit_mix_b2_1", {24'd0, instr_byte2}, 32'h55);
        check("lit_mix_pc1", {16'd0, instr_pc}, 32'h0001);
        cyc(1'b1, 8'h85, 1'b1);
        cyc(1'b1, 8'h40, 1'b1);
        cyc(1'b1, 8'h41, 1'b1);
        check("lit_mix_pc2", {16'd0, instr_pc}, 32'h0004);
        check("lit_mix_len2", {30'd0, instr_length}, 32'd3);
        cyc(1'b1, 8'h04, 1'b1);
        check("lit_mix_pc3", {16'd0, instr_pc}, 32'h0007);
        cyc(1'b0, 8'h00, 1'b1);

        // Fill to full, then one pop admits exactly one byte
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'h0200);
        repeat (8) cyc(1'b1, 8'h00, 1'b0);
        check("lit_full_count", {29'd0, queue_count}, 32'd4);
        check("lit_full_ready", {31'd0, byte_ready}, 32'd0);
        cyc(1'b1, 8'h00, 1'b1);
        check("lit_pop_count", {29'd0, queue_count}, 32'd3);
        check("lit_pop_head", {16'd0, instr_pc}, 32'h0201);
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        check("lit_refill_count", {29'd0, queue_count}, 32'd4);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        check("lit_drain_count", {29'd0, queue_count}, 32'd0);

        // Flush in the middle of ANL dir,#imm
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 16'h0300);
        cyc(1'b1, 8'h53, 1'b1);
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 16'h0100);
        check("lit_flush_ready", {31'd0, byte_ready}, 32'd0);
        cyc(1'b1, 8'h00, 1'b1);
        check("lit_flush_opc", {24'd0, instr_opcode}, 32'h00);
        check("lit_flush_pc", {16'd0, instr_pc}, 32'h0100);
        check("lit_flush_cnt", {29'd0, queue_count}, 32'd1);
        cyc(1'b1, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'hE4, 1'b0);
        cyc(1'b1, 8'hE4, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 16'h0400);
        check("lit_flush_pop", {29'd0, queue_count}, 32'd0);

        // PC wrap
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'hFFFF);
        cyc(1'b1, 8'h74, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0);
        check("lit_wrap_pc", {16'd0, instr_pc}, 32'hFFFF);
        check("lit_wrap_len", {30'd0, instr_length}, 32'd2);
        cyc(1'b1, 8'h00, 1'b1);
        check("lit_wrap_next", {16'd0, instr_pc}, 32'h0001);
        cyc(1'b0, 8'h00, 1'b1);

        // Trap opcode 0xA5
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'h0500);
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        check("lit_trap_count", {29'd0, queue_count}, 32'd1);
        check("lit_trap_ill", {31'd0, instr_illegal}, 32'd1);
        check("lit_trap_ready", {31'd0, byte_ready}, 32'd0);
        repeat (3) cyc(1'b1, 8'h00, 1'b0);
        check("lit_trap_hold", {31'd0, byte_ready}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'h0600);
        cyc(1'b1, 8'h00, 1'b0);
        check("lit_trap_rel", {31'd0, byte_ready}, 32'd1);
        check("lit_trap_ill0", {31'd0, instr_illegal}, 32'd0);
`else
        check("lit_a5_count", {29'd0, queue_count}, 32'd2);
        check("lit_a5_len", {30'd0, instr_length}, 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        check("lit_a5_next", {16'd0, instr_pc}, 32'h0501);
`endif

        // Reset wins over flush
        reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'h1234);
        reset = 1'b1;
        cyc(1'b1, 8'h04, 1'b0);
        check("lit_prio_pc", {16'd0, instr_pc}, 32'h0000);
        repeat (2) cyc(1'b0, 8'h00, 1'b1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opcode_fetch_queue.md
Name: opcode_fetch_queue

Overview:
- Sequential front end sitting between code memory and the combinational opcode decoder of the 8051-class core.
- Accepts a byte stream from code memory and assembles complete 1-, 2- or 3-byte instructions using the 8051 opcode length table.
- Tags each instruction with its PC and buffers it in a parametrised first-word-fall-through queue that the decode/execute stage drains.
- Supports pipeline flush/redirect on jumps.

Parameters:
- ADDR_WIDTH, 16, width of the code address / PC.
- QUEUE_DEPTH, 4, number of complete instructions buffered (power of 2, ≥2).
- RESET_PC, 16'h0000, PC loaded at reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- byte_valid  in  1  code byte present.
- byte_data  in  8  code byte.
- byte_ready  out  1  block accepts byte this cycle.
- flush  in  1  discard all state and redirect.
- flush_pc  in  ADDR_WIDTH  new PC on flush.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  consumer pops the head.
- instr_opcode  out  8  head opcode byte.
- instr_byte1  out  8  first operand byte (0 if absent).
- instr_byte2  out  8  second operand byte (0 if absent).
- instr_length  out  2  1, 2 or 3.
- instr_pc  out  ADDR_WIDTH  address of the opcode byte.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  entries held.

Behaviour:
- Reset (reset==0 at clock edge):
  - Queue empty; assembler in S_OPC; pc=RESET_PC.
  - All instr_* outputs 0; queue_count=0; byte_ready=0 during reset.
- Byte handshake:
  - A byte is accepted when byte_valid && byte_ready.
  - byte_ready = reset && !flush && (queue_count != QUEUE_DEPTH). Conservative: low whenever the queue is full, in any state.
- Every accepted byte increments pc by 1, modulo 2^ADDR_WIDTH (wraps from all-ones to 0).
- Assembler FSM:
  - S_OPC, accept:
    - Latch opcode and start_pc=pc.
    - Compute len from the 8051 length table.
    - len==1: push entry same edge, stay in S_OPC.
    - Otherwise go to S_B1.
  - S_B1, accept:
    - Latch byte1.
    - len==2: push entry, go to S_OPC.
    - Otherwise go to S_B2.
  - S_B2, accept: latch byte2, push entry, go to S_OPC.
  - No accept: hold state.
- Length table anchors:
  - 1 byte: Rn and @Ri forms; INC/DEC A; RR/RRC/RL/RLC/SWAP; MUL/DIV/DA/CLR/CPL A; NOP 0x00.
  - 2 bytes: A,#imm; A,dir; INC/DEC dir; PUSH/POP; XCH A,dir; MOV Rn,#imm; MOV dir,Rn; MOV Rn,dir; MOV A,dir; MOV dir,A; MOV @Ri,#imm.
  - 3 bytes: ANL/ORL/XRL dir,#imm; MOV dir,#imm (0x75); MOV dir,dir (0x85).
  - Unlisted opcodes: length 1.
- Queue:
  - FWFT; head fields drive instr_* combinationally from storage; instr_valid = queue_count != 0.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop when empty is ignored. Push when full cannot occur because of byte_ready.
  - Latency: last byte accepted at edge N → instr_valid high after edge N if the queue was empty.
- Flush (reset high, flush==1 at an edge):
  - Queue emptied; FSM to S_OPC; pc=flush_pc.
  - Any partial instruction dropped; a concurrent pop is ignored; byte_ready=0 that cycle.
  - Flush during a partial 3-byte assembly leaves no residue.
- Reset has priority over flush.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- When defined:
  - Opcode 0xA5 (unused in 8051) is pushed as a 1-byte entry with extra output port instr_illegal=1 on that entry.
  - The assembler then enters S_HALT: byte_ready=0 until flush or reset.
  - instr_illegal is 0 on all other entries and 0 at reset.
- When undefined:
  - No instr_illegal port and no S_HALT.
  - 0xA5 is treated as a normal 1-byte opcode.

Test Plan:
- Reset: stream 0x24,0x10 (ADD A,#10h) with instr_ready=0 → instr_valid after the 2nd byte; opcode=0x24, byte1=0x10, byte2=0, length=2, pc=0x0000.
- Mixed stream 0x28, 0x75,0x30,0x55, 0x85,0x40,0x41, 0x04 with instr_ready=1 → entries emitted in order with lengths 1,3,3,1 and PCs 0,1,4,7.
- Fill: QUEUE_DEPTH=4, instr_ready=0, stream eight 1-byte opcodes → queue_count=4, byte_ready=0. Then one pop → exactly one more byte accepted, count stays 4.
- Flush mid-instruction: after 0x53,0x20 accepted, pulse flush with flush_pc=0x0100, then send 0x00 → single entry, opcode 0x00, pc=0x0100, no 0x53 entry.
- Wrap: flush_pc=0xFFFF, stream 0x74,0x5A → pc=0xFFFF, length=2; the next opcode is tagged pc=0x0001.
- ILLEGAL_TRAP_EN defined: stream 0xA5,0x00 → one entry with instr_illegal=1; byte_ready stays 0 until flush; with the macro undefined, two normal entries.
